lif_array_scheduler: RTL and testbench

LIF_ARRAY_SCHEDULER -- requirements
Module: lif_array_scheduler

---
 rtl/lif_array_scheduler.sv | 173 +++++++++++++++++
 tb/tb_lif_array_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_array_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : lif_array_scheduler
//  Brief    : Time-multiplexed leaky integrate-and-fire array. One shared
//             update datapath walks NUM_NEURONS potentials per timestep and
//             emits each fire as a valid/ready spike event.
//             Optional macro LIF_SCHED_REFRACTORY_EN adds a one-step
//             refractory period per neuron.
//  Revision : 1.0 - initial release
// ============================================================================
module lif_array_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int POT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_start,
    input  logic [NUM_NEURONS-1:0]         spike_in_vec,
    input  logic [7:0]                     leak_factor,
    input  logic [7:0]                     threshold,
    output logic                           spike_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] spike_id,
    input  logic                           spike_ready,
    output logic                           busy,
    output logic                           step_done
);

    localparam int              c_IDX_W     = $clog2(NUM_NEURONS);
    localparam int              c_SUM_W     = POT_W + 2;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_NEURONS - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_UPDATE = 2'd1;
    localparam logic [1:0] c_ST_EMIT   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [POT_W-1:0]       r_pot [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] r_spk;
    logic [7:0]             r_leak;
    logic [7:0]             r_thr;
    logic                   r_spike_valid;
    logic [c_IDX_W-1:0]     r_spike_id;

    logic [POT_W-1:0]       w_pot_cur;
    logic [POT_W-1:0]       w_pot_new;
    logic [c_SUM_W-1:0]     w_sum;
    logic                   w_refr;
    logic                   w_in;
    logic                   w_fire;
    logic                   w_last;
    logic                   w_accept;

`ifdef LIF_SCHED_REFRACTORY_EN
    logic [NUM_NEURONS-1:0] r_refr;

    // A neuron that fired last step neither fires nor integrates now; leak still applies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refr <= '0;
        end else if (r_state == c_ST_UPDATE) begin
            r_refr[r_idx] <= w_fire;
        end
    end

    assign w_refr = r_refr[r_idx];
`else
    assign w_refr = 1'b0;
`endif

    assign w_pot_cur = r_pot[r_idx];
    assign w_last    = (r_idx == c_LAST_IDX);
    assign w_accept  = r_spike_valid & spike_ready;
    assign w_in      = r_spk[r_idx] & ~w_refr;
    assign w_fire    = ~w_refr & ({2'b00, w_pot_cur} >= c_SUM_W'(r_thr));

    // Sum is two's complement at POT_W+2 bits: MSB set means it went negative.
    assign w_sum = {2'b00, w_pot_cur}
                 + (w_in ? c_SUM_W'(r_thr[7:2]) : '0)
                 - c_SUM_W'(r_leak);

    always_comb begin
        w_pot_new = w_sum[POT_W-1:0];
        if (w_fire) begin
            w_pot_new = '0;
        end else if (w_sum[c_SUM_W-1]) begin
            w_pot_new = '0;
        end else if (w_sum[c_SUM_W-2]) begin
            w_pot_new = '1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (step_start) w_state_nxt = c_ST_UPDATE;
            end
            c_ST_UPDATE: begin
                if (w_fire)      w_state_nxt = c_ST_EMIT;
                else if (w_last) w_state_nxt = c_ST_DONE;
            end
            c_ST_EMIT: begin
                if (w_accept) w_state_nxt = w_last ? c_ST_DONE : c_ST_UPDATE;
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_spk         <= '0;
            r_leak        <= '0;
            r_thr         <= '0;
            r_spike_valid <= 1'b0;
            r_spike_id    <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_pot[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (step_start) begin
                        r_spk  <= spike_in_vec;
                        r_leak <= leak_factor;
                        r_thr  <= threshold;
                        r_idx  <= '0;
                    end
                end
                c_ST_UPDATE: begin
                    r_pot[r_idx] <= w_pot_new;
                    if (w_fire) begin
                        r_spike_valid <= 1'b1;
                        r_spike_id    <= r_idx;
                    end else if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_ST_EMIT: begin
                    if (w_accept) begin
                        r_spike_valid <= 1'b0;
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign spike_valid = r_spike_valid;
    assign spike_id    = r_spike_id;
    assign busy        = (r_state != c_ST_IDLE);
    assign step_done   = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lif_array_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lif_array_scheduler
//  Brief    : Self-checking bench for lif_array_scheduler (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lif_array_scheduler;

    localparam int NN = 8;
    localparam int PW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_start;
    logic [NN-1:0] spike_in_vec;
    logic [7:0]    leak_factor;
    logic [7:0]    threshold;
    logic          spike_valid;
    logic [IW-1:0] spike_id;
    logic          spike_ready;
    logic          busy;
    logic          step_done;

    int checks = 0;
    int errors = 0;
    int model_pot [NN];
    int exp_ids [$];

    typedef struct {
        logic [NN-1:0] spk;
        logic [7:0]    leak;
        logic [7:0]    thr;
        int            stall;
        int            restart;
        logic [NN-1:0] exp_mask;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    lif_array_scheduler #(.NUM_NEURONS(NN), .POT_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .step_start   (step_start),
        .spike_in_vec (spike_in_vec),
        .leak_factor  (leak_factor),
        .threshold    (threshold),
        .spike_valid  (spike_valid),
        .spike_id     (spike_id),
        .spike_ready  (spike_ready),
        .busy         (busy),
        .step_done    (step_done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: one whole timestep over all neurons, straight from the update rule.
    function automatic logic [NN-1:0] model_step(input logic [NN-1:0] spk, input int leak, input int thr);
        logic [NN-1:0] m;
        int v;
        m = '0;
        for (int i = 0; i < NN; i++) begin
            if (model_pot[i] >= thr) begin
                model_pot[i] = 0;
                m[i] = 1'b1;
                exp_ids.push_back(i);
            end else begin
                v = model_pot[i] + (spk[i] ? thr / 4 : 0) - leak;
                if (v < 0) v = 0;
                if (v > (1 << PW) - 1) v = (1 << PW) - 1;
                model_pot[i] = v;
            end
        end
        return m;
    endfunction

    task automatic check_pots();
        for (int i = 0; i < NN; i++) begin
            check($sformatf("pot%0d", i), dut.r_pot[i], model_pot[i]);
        end
    endtask

    task automatic run_step(input logic [NN-1:0] spk, input logic [7:0] leak, input logic [7:0] thr,
                            input int stall, input int restart_at, output logic [NN-1:0] seen);
        logic [NN-1:0] exp_mask;
        int nfire;
        int busy_cyc;
        int done_cnt;
        int wait_n;
        int cur_id;
        bit finished;
        exp_ids.delete();
        exp_mask = model_step(spk, int'(leak), int'(thr));
        nfire    = $countones(exp_mask);
        seen     = '0;
        busy_cyc = 0;
        done_cnt = 0;
        wait_n   = 0;
        cur_id   = 0;
        finished = 1'b0;
        @(negedge clk);
        step_start   = 1'b1;
        spike_in_vec = spk;
        leak_factor  = leak;
        threshold    = thr;
        spike_ready  = (stall == 0);
        @(negedge clk);
        step_start   = 1'b0;
        spike_in_vec = NN'($urandom);
        leak_factor  = 8'($urandom);
        threshold    = 8'($urandom);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (busy) busy_cyc++;
            if (spike_valid) begin
                if (wait_n == 0) begin
                    cur_id = int'(spike_id);
                    seen[spike_id] = 1'b1;
                    if (exp_ids.size() == 0) check("spike_unexpected", spike_id, -1);
                    else                     check("spike_id_order", spike_id, exp_ids.pop_front());
                end else begin
                    check("spike_id_hold", spike_id, cur_id);
                end
                wait_n++;
                spike_ready = (wait_n >= stall);
            end else begin
                wait_n = 0;
                spike_ready = (stall == 0);
            end
            if (step_done) begin
                done_cnt++;
                finished = 1'b1;
            end
            step_start = (cyc == restart_at);
            if (!finished) @(negedge clk);
        end
        step_start = 1'b0;
        check("step_done_seen", done_cnt, 1);
        check("step_cycles", busy_cyc, NN + 1 + nfire * ((stall > 0) ? stall : 1));
        check("fires_missing", exp_ids.size(), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_step_done", step_done, 0);
            check("idle_spike_valid", spike_valid, 0);
        end
        check_pots();
    endtask

    initial begin
        logic [NN-1:0] seen;
        int bad;

        // Four steps of +10, fire-all on the fifth; then leak-down of pot[2] to 0.
        tbl[0]  = '{8'hFF, 8'd0, 8'd40, 0, -1, 8'h00};
        tbl[1]  = '{8'hFF, 8'd0, 8'd40, 0, -1, 8'h00};
        tbl[2]  = '{8'hFF, 8'd0, 8'd40, 0,  2, 8'h00};
        tbl[3]  = '{8'hFF, 8'd0, 8'd40, 0, -1, 8'h00};
        tbl[4]  = '{8'hFF, 8'd0, 8'd40, 0, -1, 8'hFF};
        tbl[5]  = '{8'h04, 8'd0, 8'd40, 0, -1, 8'h00};
        tbl[6]  = '{8'h00, 8'd3, 8'd40, 0, -1, 8'h00};
        tbl[7]  = '{8'h00, 8'd3, 8'd40, 0, -1, 8'h00};
        tbl[8]  = '{8'h00, 8'd3, 8'd40, 0, -1, 8'h00};
        tbl[9]  = '{8'h00, 8'd3, 8'd40, 0, -1, 8'h00};
        tbl[10] = '{8'h00, 8'd3, 8'd40, 0,  4, 8'h00};
        tbl[11] = '{8'h08, 8'd0, 8'd8,  0, -1, 8'h00};
        tbl[12] = '{8'h08, 8'd0, 8'd8,  0, -1, 8'h00};
        tbl[13] = '{8'h08, 8'd0, 8'd8,  0, -1, 8'h00};
        tbl[14] = '{8'h08, 8'd0, 8'd8,  0, -1, 8'h00};
        tbl[15] = '{8'h08, 8'd0, 8'd8,  5, -1, 8'h08};
        tbl[16] = '{8'h00, 8'd0, 8'd0,  2, -1, 8'hFF};
        tbl[17] = '{8'h5A, 8'd0, 8'd0,  0, -1, 8'hFF};

        for (int i = 0; i < NN; i++) model_pot[i] = 0;
        rst          = 1'b1;
        step_start   = 1'b0;
        spike_in_vec = '0;
        leak_factor  = '0;
        threshold    = '0;
        spike_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_id", spike_id, 0);
        check_pots();
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_step(tbl[i].spk, tbl[i].leak, tbl[i].thr, tbl[i].stall, tbl[i].restart, seen);
            check($sformatf("table_mask_%0d", i), seen, tbl[i].exp_mask);
        end

        // Reset in the middle of a held spike event.
        @(negedge clk);
        step_start   = 1'b1;
        spike_in_vec = '0;
        leak_factor  = '0;
        threshold    = '0;
        spike_ready  = 1'b0;
        @(negedge clk);
        step_start = 1'b0;
        for (int k = 0; k < 20 && !spike_valid; k++) @(negedge clk);
        check("emit_reached", spike_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_spike_valid", spike_valid, 0);
        check("midrst_spike_id", spike_id, 0);
        check("midrst_step_done", step_done, 0);
        for (int i = 0; i < NN; i++) model_pot[i] = 0;
        check_pots();
        @(negedge clk);
        rst = 1'b0;
        spike_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (spike_valid || step_done || busy) bad++;
        end
        check("post_rst_quiet", bad, 0);

        for (int s = 0; s < 24; s++) begin
            run_step(NN'($urandom), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 60)),
                     int'($urandom_range(0, 3)), (s % 4 == 0) ? 3 : -1, seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
